// File: rtl/cpu_run_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_run_ctrl_if                                                  |
// | Brief   : Control/observation bundle between run controller and RISC-V core|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface cpu_run_ctrl_if;
    logic        cpu_rst;
    logic        cpu_ce;
    logic [3:0]  sw_out;
    logic [31:0] cpu_ip;
    logic [31:0] cpu_next;
    logic [7:0]  cpu_result;

    modport master (
        output cpu_rst, cpu_ce, sw_out,
        input  cpu_ip, cpu_next, cpu_result
    );

    modport slave (
        input  cpu_rst, cpu_ce, sw_out,
        output cpu_ip, cpu_next, cpu_result
    );
endinterface
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_run_ctrl                                                     |
// | Brief   : Launch/reset/free-run/single-step sequencer for the core, with   |
// |           jump-to-self halt detection, cycle counting and timeout.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cpu_run_ctrl #(
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 4096
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         start,
    input  wire logic         stop,
    input  wire logic         mode,
    input  wire logic         step,
    input  wire logic [3:0]   switch,
    cpu_run_ctrl_if.master    cpu,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [7:0]        result,
    output logic [15:0]       cycles
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_reset = 3'd1;
    localparam logic [2:0] c_run   = 3'd2;
    localparam logic [2:0] c_pause = 3'd3;
    localparam logic [2:0] c_step  = 3'd4;
    localparam logic [2:0] c_done  = 3'd5;
    localparam logic [2:0] c_tmo   = 3'd6;

    localparam int                c_rcw      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_rcw-1:0]  c_rst_last = c_rcw'(RST_CYCLES - 1);
    localparam logic [15:0]       c_max      = 16'(MAX_CYCLES);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [c_rcw-1:0] r_rst_cnt;
    logic             r_mode;
    logic             r_cpu_rst;
    logic             r_cpu_ce;
    logic [3:0]       r_sw_out;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;
    logic [7:0]       r_result;
    logic [15:0]      r_cycles;

    logic             w_exec;
    logic             w_halt;
    logic             w_tmo;
    logic             w_launch;
    logic [15:0]      w_cyc_inc;

    // An executed cycle is one where the core actually commits state.
    assign w_exec    = r_cpu_ce & ~r_cpu_rst;
    assign w_halt    = w_exec & (cpu.cpu_next == cpu.cpu_ip);
    assign w_cyc_inc = (r_cycles == 16'hFFFF) ? r_cycles : r_cycles + 16'd1;
    assign w_tmo     = w_exec & ~w_halt & (w_cyc_inc == c_max);
    assign w_launch  = start & ~stop &
                       ((r_state == c_idle) | (r_state == c_done) | (r_state == c_tmo));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle, c_done, c_tmo: begin
                if (start) w_state_nxt = c_reset;
            end
            c_reset: begin
                if (r_rst_cnt == c_rst_last) w_state_nxt = r_mode ? c_pause : c_run;
            end
            c_run, c_step: begin
                if (w_halt)                 w_state_nxt = c_done;
                else if (w_tmo)             w_state_nxt = c_tmo;
                else if (r_state == c_step) w_state_nxt = c_pause;
            end
            c_pause: begin
                if (step) w_state_nxt = c_step;
            end
            default: w_state_nxt = c_idle;
        endcase
        if (stop) w_state_nxt = c_idle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_idle;
            r_rst_cnt <= '0;
            r_mode    <= 1'b0;
            r_cpu_rst <= 1'b1;
            r_cpu_ce  <= 1'b0;
            r_sw_out  <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_result  <= 8'd0;
            r_cycles  <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            // Status outputs are decoded from the next state so they stay registered.
            r_cpu_rst <= (w_state_nxt == c_idle) | (w_state_nxt == c_reset);
            r_cpu_ce  <= (w_state_nxt == c_run)  | (w_state_nxt == c_step);
            r_busy    <= (w_state_nxt == c_reset) | (w_state_nxt == c_run) |
                         (w_state_nxt == c_pause) | (w_state_nxt == c_step);
            r_done    <= (w_state_nxt == c_done);
            r_timeout <= (w_state_nxt == c_tmo);

            if (w_launch) begin
                r_sw_out  <= switch;
                r_mode    <= mode;
                r_cycles  <= 16'd0;
                r_rst_cnt <= '0;
            end else begin
                if ((r_state == c_reset) && (r_rst_cnt != c_rst_last))
                    r_rst_cnt <= r_rst_cnt + 1'b1;
                // An abort freezes the counters at their pre-abort values.
                if (w_exec && !stop)
                    r_cycles <= w_cyc_inc;
                if (w_halt && !stop)
                    r_result <= cpu.cpu_result;
            end
        end
    end

    assign cpu.cpu_rst = r_cpu_rst;
    assign cpu.cpu_ce  = r_cpu_ce;
    assign cpu.sw_out  = r_sw_out;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign result      = r_result;
    assign cycles      = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_cpu_run_ctrl                                                  |
// | Brief   : Directed bench for cpu_run_ctrl with a tiny PC-stepping core.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, mode = 1'b0, step = 1'b0;
    logic [3:0]  sw = 4'd0;
    logic        busy, done, timeout;
    logic [7:0]  result;
    logic [15:0] cycles;

    logic        t_start = 1'b0;
    logic        t_stop = 1'b0, t_mode = 1'b0, t_step = 1'b0;
    logic [3:0]  t_sw = 4'd0;
    logic        t_busy, t_done, t_timeout;
    logic [7:0]  t_result;
    logic [15:0] t_cycles;

    logic [31:0] pc, halt_pc = 32'hFFFF_FFFF;
    logic [31:0] tpc, t_halt_pc = 32'hFFFF_FFFF;
    logic [7:0]  res = 8'd0, t_res = 8'd0;

    int checks = 0;
    int errors = 0;

    cpu_run_ctrl_if cif ();
    cpu_run_ctrl_if tif ();

    cpu_run_ctrl #(.RST_CYCLES(2), .MAX_CYCLES(4096)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .step(step),
        .switch(sw), .cpu(cif), .busy(busy), .done(done), .timeout(timeout),
        .result(result), .cycles(cycles)
    );

    cpu_run_ctrl #(.RST_CYCLES(2), .MAX_CYCLES(16)) dut_to (
        .clk(clk), .rst(rst), .start(t_start), .stop(t_stop), .mode(t_mode), .step(t_step),
        .switch(t_sw), .cpu(tif), .busy(t_busy), .done(t_done), .timeout(t_timeout),
        .result(t_result), .cycles(t_cycles)
    );

    always #5 clk = ~clk;

    // Model core: PC advances by 4 per executed cycle, jumps to self at halt_pc.
    always @(posedge clk) begin
        if (cif.cpu_rst)     pc <= 32'd0;
        else if (cif.cpu_ce) pc <= cif.cpu_next;
        if (tif.cpu_rst)     tpc <= 32'd0;
        else if (tif.cpu_ce) tpc <= tif.cpu_next;
    end
    assign cif.cpu_ip     = pc;
    assign cif.cpu_next   = (pc == halt_pc) ? pc : pc + 32'd4;
    assign cif.cpu_result = res;
    assign tif.cpu_ip     = tpc;
    assign tif.cpu_next   = (tpc == t_halt_pc) ? tpc : tpc + 32'd4;
    assign tif.cpu_result = t_res;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++; if (cif.cpu_rst !== 1'b1) begin errors++; $display("FAIL rst_cpu_rst got %b exp 1", cif.cpu_rst); end
        checks++; if (cif.cpu_ce !== 1'b0) begin errors++; $display("FAIL rst_cpu_ce got %b exp 0", cif.cpu_ce); end
        checks++; if ({busy, done, timeout} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {busy, done, timeout}); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL rst_result got %h exp 00", result); end
        checks++; if (cycles !== 16'd0) begin errors++; $display("FAIL rst_cycles got %0d exp 0", cycles); end
        checks++; if (cif.sw_out !== 4'd0) begin errors++; $display("FAIL rst_sw_out got %0d exp 0", cif.sw_out); end
    endtask

    task automatic test_free_run();
        int rst_n = 0;
        int exec_n = 0;
        sw = 4'd5; mode = 1'b0; res = 8'h05; halt_pc = 32'd156;  // 40th executed cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({busy, cif.cpu_rst, cif.cpu_ce} !== 3'b110) begin errors++; $display("FAIL fr_launch got %b exp 110", {busy, cif.cpu_rst, cif.cpu_ce}); end
        for (int i = 0; i < 200; i++) begin
            if (busy && cif.cpu_rst) rst_n++;
            if (cif.cpu_ce && !cif.cpu_rst) exec_n++;
            if (done) break;
            if (i == 10) sw = 4'd9;
            tick();
        end
        checks++; if (rst_n !== 2) begin errors++; $display("FAIL fr_rst_len got %0d exp 2", rst_n); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL fr_done got %b exp 1", done); end
        checks++; if (result !== 8'h05) begin errors++; $display("FAIL fr_result got %h exp 05", result); end
        checks++; if (cycles !== 16'd40) begin errors++; $display("FAIL fr_cycles got %0d exp 40", cycles); end
        checks++; if (exec_n !== 40) begin errors++; $display("FAIL fr_exec got %0d exp 40", exec_n); end
        checks++; if (cif.sw_out !== 4'd5) begin errors++; $display("FAIL fr_sw_out got %0d exp 5", cif.sw_out); end
        checks++; if ({busy, cif.cpu_rst, cif.cpu_ce} !== 3'b000) begin errors++; $display("FAIL fr_frozen got %b exp 000", {busy, cif.cpu_rst, cif.cpu_ce}); end
    endtask

    task automatic test_relaunch();
        sw = 4'd3; res = 8'h18; halt_pc = 32'd24;  // 7th executed cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL rl_clear got %b exp 01", {done, busy}); end
        checks++; if (cycles !== 16'd0) begin errors++; $display("FAIL rl_cycles0 got %0d exp 0", cycles); end
        checks++; if (result !== 8'h05) begin errors++; $display("FAIL rl_result_hold got %h exp 05", result); end
        checks++; if (cif.sw_out !== 4'd3) begin errors++; $display("FAIL rl_sw_out got %0d exp 3", cif.sw_out); end
        for (int i = 0; i < 50 && !done; i++) tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rl_done got %b exp 1", done); end
        checks++; if (result !== 8'h18) begin errors++; $display("FAIL rl_result got %h exp 18", result); end
        checks++; if (cycles !== 16'd7) begin errors++; $display("FAIL rl_cycles got %0d exp 7", cycles); end
    endtask

    task automatic test_single_step();
        mode = 1'b1; res = 8'h2A; halt_pc = 32'd12;  // halt on 4th step
        start = 1'b1;
        tick();
        start = 1'b0; mode = 1'b0;
        step = 1'b1;  // step during RESET must be ignored
        tick();
        step = 1'b0;
        tick();
        checks++; if ({busy, cif.cpu_rst, cif.cpu_ce} !== 3'b100) begin errors++; $display("FAIL ss_pause got %b exp 100", {busy, cif.cpu_rst, cif.cpu_ce}); end
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            checks++; if (cif.cpu_ce !== 1'b1) begin errors++; $display("FAIL ss_step_ce got %b exp 1", cif.cpu_ce); end
            tick();
            checks++; if (cif.cpu_ce !== 1'b0) begin errors++; $display("FAIL ss_pause_ce got %b exp 0", cif.cpu_ce); end
        end
        checks++; if (cycles !== 16'd3) begin errors++; $display("FAIL ss_cycles3 got %0d exp 3", cycles); end
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL ss_paused got %b exp 10", {busy, done}); end
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        checks++; if ({done, busy, cif.cpu_ce} !== 3'b100) begin errors++; $display("FAIL ss_done got %b exp 100", {done, busy, cif.cpu_ce}); end
        checks++; if (cycles !== 16'd4) begin errors++; $display("FAIL ss_cycles4 got %0d exp 4", cycles); end
        checks++; if (result !== 8'h2A) begin errors++; $display("FAIL ss_result got %h exp 2a", result); end
    endtask

    task automatic test_abort();
        sw = 4'd7; halt_pc = 32'hFFFF_FFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();  // 2 reset cycles, then 5 executed cycles
        checks++; if (cycles !== 16'd5) begin errors++; $display("FAIL ab_run_cycles got %0d exp 5", cycles); end
        start = 1'b1;
        tick();
        checks++; if ({busy, cycles} !== {1'b1, 16'd6}) begin errors++; $display("FAIL ab_start_ignored got %b/%0d exp 1/6", busy, cycles); end
        stop = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        checks++; if ({busy, cif.cpu_rst, cif.cpu_ce, done} !== 4'b0100) begin errors++; $display("FAIL ab_idle got %b exp 0100", {busy, cif.cpu_rst, cif.cpu_ce, done}); end
        checks++; if (cycles !== 16'd6) begin errors++; $display("FAIL ab_cycles_hold got %0d exp 6", cycles); end
        checks++; if (result !== 8'h2A) begin errors++; $display("FAIL ab_result_hold got %h exp 2a", result); end
        tick();
        checks++; if ({busy, cif.sw_out} !== {1'b0, 4'd7}) begin errors++; $display("FAIL ab_stay_idle got %b/%0d exp 0/7", busy, cif.sw_out); end
    endtask

    task automatic test_timeout();
        t_res = 8'h77; t_halt_pc = 32'hFFFF_FFFF;
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        for (int i = 0; i < 60 && !t_timeout && !t_done; i++) tick();
        checks++; if ({t_timeout, t_done, t_busy, tif.cpu_ce} !== 4'b1000) begin errors++; $display("FAIL to_flag got %b exp 1000", {t_timeout, t_done, t_busy, tif.cpu_ce}); end
        checks++; if (t_cycles !== 16'd16) begin errors++; $display("FAIL to_cycles got %0d exp 16", t_cycles); end
        checks++; if (t_result !== 8'h00) begin errors++; $display("FAIL to_result got %h exp 00", t_result); end
        t_halt_pc = 32'd60;  // halt lands on the 16th executed cycle
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        checks++; if ({t_timeout, t_busy} !== 2'b01) begin errors++; $display("FAIL to_relaunch got %b exp 01", {t_timeout, t_busy}); end
        for (int i = 0; i < 60 && !t_timeout && !t_done; i++) tick();
        checks++; if ({t_done, t_timeout} !== 2'b10) begin errors++; $display("FAIL to_halt_wins got %b exp 10", {t_done, t_timeout}); end
        checks++; if (t_cycles !== 16'd16) begin errors++; $display("FAIL to_halt_cycles got %0d exp 16", t_cycles); end
        checks++; if (t_result !== 8'h77) begin errors++; $display("FAIL to_halt_result got %h exp 77", t_result); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_relaunch();
        test_single_step();
        test_abort();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
